// File: rtl/tl_tx_credit_arb_if.sv
// Handshake and credit bus between the TLP sources/DLL side and tl_tx_credit_arb.
// master drives requests, credit limits and pkt_done; slave is the arbiter.
interface tl_tx_credit_arb_if #(
  parameter int NUM_CLS = 3,
  parameter int LEN_W   = 10
);
  logic                       fc_valid;
  logic [63:0]                fc_limit;
  logic [NUM_CLS-1:0]         req_valid;
  logic [NUM_CLS*LEN_W-1:0]   req_len;
  logic [NUM_CLS-1:0]         req_has_data;
  logic                       pkt_done;
  logic [NUM_CLS-1:0]         grant;
  logic                       busy;
  logic [NUM_CLS-1:0]         credit_block;
  logic [63:0]                consumed;

  modport master (
    output fc_valid, fc_limit, req_valid, req_len, req_has_data, pkt_done,
    input  grant, busy, credit_block, consumed
  );

  modport slave (
    input  fc_valid, fc_limit, req_valid, req_len, req_has_data, pkt_done,
    output grant, busy, credit_block, consumed
  );
endinterface

// File: rtl/tl_tx_credit_arb.sv
// Credit-gated round-robin TX scheduler for P/NP/CPL TLPs; grant one cycle after eligibility,
// held until pkt_done. Optional macro TL_INF_CREDIT_EN: zero fields in the first FC snapshot are infinite.
module tl_tx_credit_arb #(
  parameter int NUM_CLS = 3,
  parameter int LEN_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  tl_tx_credit_arb_if.slave bus
);

  typedef struct packed {
    logic [11:0] ph;
    logic [11:0] pd;
    logic [7:0]  nph;
    logic [11:0] npd;
    logic [7:0]  cplh;
    logic [11:0] cpld;
  } tl_credit_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [NUM_CLS-1:0] grant_q, grant_d;
  logic [NUM_CLS-1:0] blk_q, blk_d;
  logic [1:0]         rr_q, rr_d;
  logic               seen_q, seen_d;
  tl_credit_t         lim_q, lim_d;
  tl_credit_t         cons_q, cons_d;
  tl_credit_t         fc_in;
  logic [5:0]         inf_mask;

  logic [11:0]        dneed [NUM_CLS];
  logic [NUM_CLS-1:0] hdr_ok, dat_ok, cls_ok, elig;
  logic               found;
  logic [1:0]         win;

  assign fc_in = tl_credit_t'(bus.fc_limit);

`ifdef TL_INF_CREDIT_EN
  logic [5:0] inf_q, inf_d;
  assign inf_mask = inf_q;

  always_comb begin
    inf_d = inf_q;
    if (bus.fc_valid && !seen_q) begin
      inf_d = {fc_in.cpld == '0, fc_in.cplh == '0, fc_in.npd == '0,
               fc_in.nph == '0, fc_in.pd == '0, fc_in.ph == '0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inf_q <= '0;
    else        inf_q <= inf_d;
  end
`else
  assign inf_mask = '0;
`endif

  // Modular test: remaining credit after this packet must not have gone "negative".
  function automatic logic fits12(input logic [11:0] lim, input logic [11:0] cons,
                                  input logic [11:0] need);
    logic [11:0] d;
    d = lim - cons - need;
    return d <= 12'h800;
  endfunction

  function automatic logic fits8(input logic [7:0] lim, input logic [7:0] cons,
                                 input logic [7:0] need);
    logic [7:0] d;
    d = lim - cons - need;
    return d <= 8'h80;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CLS; i++) begin
      logic [LEN_W-1:0] len;
      logic [11:0]      lenx;
      len  = bus.req_len[i*LEN_W +: LEN_W];
      lenx = (len == '0) ? 12'(1 << LEN_W) : 12'(len);
      dneed[i] = bus.req_has_data[i] ? ((lenx + 12'd3) >> 2) : 12'd0;
    end
  end

  always_comb begin
    hdr_ok[0] = inf_mask[0] | fits12(lim_q.ph,   cons_q.ph,   12'd1);
    dat_ok[0] = inf_mask[1] | fits12(lim_q.pd,   cons_q.pd,   dneed[0]);
    hdr_ok[1] = inf_mask[2] | fits8 (lim_q.nph,  cons_q.nph,  8'd1);
    dat_ok[1] = inf_mask[3] | fits12(lim_q.npd,  cons_q.npd,  dneed[1]);
    hdr_ok[2] = inf_mask[4] | fits8 (lim_q.cplh, cons_q.cplh, 8'd1);
    dat_ok[2] = inf_mask[5] | fits12(lim_q.cpld, cons_q.cpld, dneed[2]);
    cls_ok    = hdr_ok & dat_ok;
    elig      = bus.req_valid & {NUM_CLS{seen_q}} & cls_ok;
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < NUM_CLS; k++) begin
      logic [2:0] s;
      s = {1'b0, rr_q} + 3'(k);
      if (s >= 3'(NUM_CLS)) s = s - 3'(NUM_CLS);
      if (!found && elig[s[1:0]]) begin
        found = 1'b1;
        win   = s[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    blk_d   = blk_q;
    rr_d    = rr_q;
    seen_d  = seen_q;
    lim_d   = lim_q;
    cons_d  = cons_q;

    if (bus.fc_valid) begin
      lim_d  = fc_in;
      seen_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        blk_d = bus.req_valid & {NUM_CLS{seen_q}} & ~cls_ok;
        if (found) begin
          grant_d = {{(NUM_CLS-1){1'b0}}, 1'b1} << win;
          state_d = BUSY;
          case (win)
            2'd0: begin
              cons_d.ph = cons_q.ph + 12'd1;
              cons_d.pd = cons_q.pd + dneed[0];
            end
            2'd1: begin
              cons_d.nph = cons_q.nph + 8'd1;
              cons_d.npd = cons_q.npd + dneed[1];
            end
            default: begin
              cons_d.cplh = cons_q.cplh + 8'd1;
              cons_d.cpld = cons_q.cpld + dneed[2];
            end
          endcase
        end
      end
      BUSY: begin
        if (bus.pkt_done) begin
          grant_d = '0;
          state_d = IDLE;
          rr_d    = grant_q[0] ? 2'd1 : (grant_q[1] ? 2'd2 : 2'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      blk_q   <= '0;
      rr_q    <= 2'd0;
      seen_q  <= 1'b0;
      lim_q   <= '0;
      cons_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      blk_q   <= blk_d;
      rr_q    <= rr_d;
      seen_q  <= seen_d;
      lim_q   <= lim_d;
      cons_q  <= cons_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == BUSY);
  assign bus.credit_block = blk_q;
  assign bus.consumed     = cons_q;

endmodule
